// File: rtl/mipi_csi2_capture_ctrl_pkg.sv
// Shared types for the CSI-2 capture sequencer: default widths, FSM states
// and the fv/lv edge detector used by the top level.
package mipi_csi2_capture_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int CNT_W_DEF      = 16;
  localparam int TIMEOUT_W_DEF  = 24;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT_FS,
    ST_CAPTURE
  } cap_state_t;

  typedef struct packed {
    logic fv_rise;
    logic fv_fall;
    logic lv_fall;
    logic any_edge;
  } edge_t;

  // Compares the current fv/lv sample against the previous one.
  function automatic edge_t detect_edges(input logic cur_fv, input logic cur_lv,
                                         input logic prev_fv, input logic prev_lv);
    edge_t e;
    e.fv_rise  = cur_fv & ~prev_fv;
    e.fv_fall  = ~cur_fv & prev_fv;
    e.lv_fall  = ~cur_lv & prev_lv;
    e.any_edge = (cur_fv ^ prev_fv) | (cur_lv ^ prev_lv);
    return e;
  endfunction

endpackage

// File: rtl/mipi_csi2_capture_ctrl_if.sv
// Video stream bundle (frame valid, line valid, data valid, pixel data).
// The deserializer side is consumed through 'slave', the gated capture
// stream is produced through 'master'.
interface mipi_csi2_capture_ctrl_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  fv;
  logic                  lv;
  logic                  dv;
  logic [DATA_WIDTH-1:0] dat;

  modport master (output fv, lv, dv, dat);
  modport slave  (input  fv, lv, dv, dat);
endinterface

// File: rtl/mipi_csi2_capture_ctrl_stats.sv
// Per-frame statistics: counts dv beats per line and lines per frame while
// capturing, latches the last completed values and flags geometry errors
// against the expected line/pixel counts. Counters saturate at all-ones.
module mipi_frame_stats #(
  parameter int CNT_W = 16
) (
  input  logic             img_clk,
  input  logic             resetb,
  input  logic             clear,
  input  logic             enable,
  input  logic             dv,
  input  logic             lv_fall,
  input  logic             fv_fall,
  input  logic [CNT_W-1:0] exp_lines,
  input  logic [CNT_W-1:0] exp_pixels,
  output logic [CNT_W-1:0] last_lines,
  output logic [CNT_W-1:0] last_pixels,
  output logic             err_lines,
  output logic             err_pixels
);

  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] line_inc;
  logic [CNT_W-1:0] line_total;

  assign line_inc   = (line_cnt != ALL_ONES) ? line_cnt + CNT_W'(1) : line_cnt;
  // A line ending in the same cycle as the frame is counted before the check.
  assign line_total = lv_fall ? line_inc : line_cnt;

  // Line/pixel counting, last-value latching and sticky geometry errors.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      last_lines  <= '0;
      last_pixels <= '0;
      err_lines   <= 1'b0;
      err_pixels  <= 1'b0;
    end else if (clear) begin
      pix_cnt     <= '0;
      line_cnt    <= '0;
      last_lines  <= '0;
      last_pixels <= '0;
      err_lines   <= 1'b0;
      err_pixels  <= 1'b0;
    end else if (enable) begin
      if (lv_fall) begin
        last_pixels <= pix_cnt;
        pix_cnt     <= '0;
        line_cnt    <= line_inc;
        if ((exp_pixels != '0) && (pix_cnt != exp_pixels)) begin
          err_pixels <= 1'b1;
        end
      end else if (dv && (pix_cnt != ALL_ONES)) begin
        pix_cnt <= pix_cnt + CNT_W'(1);
      end
      if (fv_fall) begin
        last_lines <= line_total;
        line_cnt   <= '0;
        pix_cnt    <= '0;
        if ((exp_lines != '0) && (line_total != exp_lines)) begin
          err_lines <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mipi_csi2_capture_ctrl.sv
// Capture sequencer for the CSI-2 deserializer. Enables the deserializer,
// aligns to a frame start, passes only whole frames to the capture stream,
// counts completed frames and supervises stream activity with a watchdog.
module mipi_csi2_capture_ctrl
  import mipi_csi2_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT_W  = TIMEOUT_W_DEF
) (
  input  logic                 img_clk,
  input  logic                 resetb,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W-1:0]     num_frames,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  input  logic [CNT_W-1:0]     exp_lines,
  input  logic [CNT_W-1:0]     exp_pixels,
  output logic                 des_enable,
  mipi_csi2_capture_ctrl_if.slave  des,
  mipi_csi2_capture_ctrl_if.master cap,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     frames_done,
  output logic [CNT_W-1:0]     last_lines,
  output logic [CNT_W-1:0]     last_pixels,
  output logic                 err_timeout,
  output logic                 err_lines,
  output logic                 err_pixels
);

  cap_state_t           state;
  logic                 prev_fv;
  logic                 prev_lv;
  logic                 stop_pending;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] wd_next;
  edge_t                edges;
  logic                 activity;
  logic                 wd_fire;
  logic                 gate;
  logic                 accept_start;
  logic                 capturing;
  logic                 last_frame;

  assign edges        = detect_edges(des.fv, des.lv, prev_fv, prev_lv);
  assign activity     = des.dv | edges.any_edge;
  assign wd_next      = activity ? '0 : wd_cnt + TIMEOUT_W'(1);
  // Fires on the idle cycle that brings the inactivity count up to the limit.
  assign wd_fire      = (state != ST_IDLE) && (timeout_cycles != '0) &&
                        (wd_next == timeout_cycles);
  assign capturing    = (state == ST_CAPTURE);
  assign gate         = (((state == ST_WAIT_FS) && edges.fv_rise) || capturing) && !wd_fire;
  assign accept_start = (state == ST_IDLE) && start && !stop;
  assign last_frame   = stop_pending || stop ||
                        ((num_frames != '0) && ((frames_done + CNT_W'(1)) == num_frames));
  assign busy         = (state != ST_IDLE);
  assign des_enable   = busy;

  // Previous fv/lv samples for edge detection.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      prev_fv <= 1'b0;
      prev_lv <= 1'b0;
    end else begin
      prev_fv <= des.fv;
      prev_lv <= des.lv;
    end
  end

  // Inactivity watchdog; held at zero while idle or disabled.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      wd_cnt <= '0;
    end else if ((state == ST_IDLE) || (timeout_cycles == '0)) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_next;
    end
  end

  // Gated capture stream, one cycle behind the deserializer.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      cap.fv  <= 1'b0;
      cap.lv  <= 1'b0;
      cap.dv  <= 1'b0;
      cap.dat <= '0;
    end else begin
      cap.fv  <= des.fv & gate;
      cap.lv  <= des.lv & gate;
      cap.dv  <= des.dv & gate;
      cap.dat <= gate ? des.dat : '0;
    end
  end

  // Capture sequencer: arming, frame alignment, frame counting and termination.
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state        <= ST_IDLE;
      done         <= 1'b0;
      frames_done  <= '0;
      err_timeout  <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wd_fire) begin
        state        <= ST_IDLE;
        done         <= 1'b1;
        err_timeout  <= 1'b1;
        stop_pending <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept_start) begin
              state        <= ST_SYNC;
              frames_done  <= '0;
              err_timeout  <= 1'b0;
              stop_pending <= 1'b0;
            end
          end
          ST_SYNC: begin
            if (stop) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else if (!des.fv) begin
              state <= ST_WAIT_FS;
            end
          end
          ST_WAIT_FS: begin
            if (stop) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else if (edges.fv_rise) begin
              state <= ST_CAPTURE;
            end
          end
          ST_CAPTURE: begin
            if (edges.fv_fall) begin
              frames_done <= frames_done + CNT_W'(1);
              if (last_frame) begin
                state        <= ST_IDLE;
                done         <= 1'b1;
                stop_pending <= 1'b0;
              end else begin
                state <= ST_WAIT_FS;
              end
            end else if (stop) begin
              stop_pending <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  mipi_frame_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .img_clk     (img_clk),
    .resetb      (resetb),
    .clear       (accept_start),
    .enable      (capturing),
    .dv          (des.dv),
    .lv_fall     (edges.lv_fall),
    .fv_fall     (edges.fv_fall),
    .exp_lines   (exp_lines),
    .exp_pixels  (exp_pixels),
    .last_lines  (last_lines),
    .last_pixels (last_pixels),
    .err_lines   (err_lines),
    .err_pixels  (err_pixels)
  );

endmodule
